// File: rtl/sync_stable_capture.sv
// sync_stable_capture: commits a synchronized bus value only after it has been
// seen unchanged for STABLE_CYCLES further edges, then offers it to a consumer
// through a valid/ready handshake. Candidates abandoned before becoming stable
// are counted as glitches; overwriting an unaccepted value sets a sticky flag.
module sync_stable_capture #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      glitch_count,
  output logic             overrun
);

  localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);
  localparam logic [3:0] STAB_PRE = 4'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] committed;
  logic [3:0]       stab_cnt;
  logic             same;
  logic             commit;
  logic             glitch;

  // Classify the current edge: repeat sample, commit point, or abandoned candidate
  always_comb begin
    same   = (sync_in == cand);
    commit = same && (stab_cnt == STAB_PRE) && (cand != committed);
    glitch = !same && (stab_cnt < STAB_MAX);
  end

  // Track the current candidate and how many repeat samples it has collected
  always_ff @(posedge clk) begin
    if (rst) begin
      cand     <= '0;
      stab_cnt <= STAB_MAX;
    end else if (!same) begin
      cand     <= sync_in;
      stab_cnt <= '0;
    end else if (stab_cnt < STAB_MAX) begin
      stab_cnt <= stab_cnt + 4'd1;
    end
  end

  // Count candidates that changed before reaching stability, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_count <= '0;
    end else if (glitch && (glitch_count != 16'hFFFF)) begin
      glitch_count <= glitch_count + 16'd1;
    end
  end

  // Commit stable values and run the consumer handshake; latest commit wins
  always_ff @(posedge clk) begin
    if (rst) begin
      committed <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (commit) begin
      committed <= cand;
      out_data  <= cand;
      out_valid <= 1'b1;
      if (out_valid && !out_ready) begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_stable_capture.sv
// Self-checking bench for sync_stable_capture: directed scenarios with literal
// expectations plus randomized runs compared every cycle against a run-length
// model of the stability rules.
module tb_sync_stable_capture;

  localparam int unsigned S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sync_in = '0;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [15:0] glitch_count;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  // model: value currently observed and how many consecutive edges it was sampled
  logic [7:0]  m_val;
  int          m_run;
  logic [7:0]  m_committed;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_overrun;
  int          m_glitch;

  sync_stable_capture #(.WIDTH(8), .STABLE_CYCLES(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .sync_in      (sync_in),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .glitch_count (glitch_count),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // A value is stable once it has been sampled S+1 consecutive times; after
  // reset the idle zero counts as long settled.
  task automatic model_step(input logic r, input logic [7:0] d, input logic rd);
    bit commit;
    if (r) begin
      m_val = '0; m_run = 1000; m_committed = '0;
      m_data = '0; m_valid = 1'b0; m_overrun = 1'b0; m_glitch = 0;
      return;
    end
    commit = 1'b0;
    if (d != m_val) begin
      if (m_run <= S && m_glitch < 65535) m_glitch++;
      m_val = d;
      m_run = 1;
    end else begin
      if (m_run < 1000) m_run++;
      if (m_run == S + 1 && m_val != m_committed) commit = 1'b1;
    end
    if (commit) begin
      if (m_valid && !rd) m_overrun = 1'b1;
      m_committed = m_val;
      m_data = m_val;
      m_valid = 1'b1;
    end else if (m_valid && rd) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cycle(input logic r, input logic [7:0] d, input logic rd);
    rst = r; sync_in = d; out_ready = rd;
    @(posedge clk);
    model_step(r, d, rd);
    #1;
  endtask

  task automatic hold(input logic [7:0] d, input logic rd, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, d, rd);
  endtask

  // compare the DUT against the model on every falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("m_valid",   32'(out_valid),    32'(m_valid));
        chk("m_data",    32'(out_data),     32'(m_data));
        chk("m_glitch",  32'(glitch_count), 32'(m_glitch));
        chk("m_overrun", 32'(overrun),      32'(m_overrun));
      end
    end
  end

  initial begin
    logic [7:0] vals [5];
    vals[0] = 8'h00; vals[1] = 8'hA5; vals[2] = 8'h3C; vals[3] = 8'h3D; vals[4] = 8'hFF;

    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    checking = 1'b1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data",  32'(out_data),  32'd0);

    // idle zero after reset produces nothing
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)));
    chk("idle_valid",   32'(out_valid),    32'd0);
    chk("idle_glitch",  32'(glitch_count), 32'd0);
    chk("idle_overrun", 32'(overrun),      32'd0);

    // latency: valid after third edge with the new value
    hold(8'hA5, 1'b1, 2);
    chk("lat_early_valid", 32'(out_valid), 32'd0);
    cycle(1'b0, 8'hA5, 1'b1);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data",  32'(out_data),  32'hA5);
    cycle(1'b0, 8'hA5, 1'b1);
    chk("lat_accept", 32'(out_valid), 32'd0);

    // glitches
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b0, 8'h3C, 1'b0);
    hold(8'h00, 1'b0, 5);
    chk("glitch1_valid", 32'(out_valid),    32'd0);
    chk("glitch1_count", 32'(glitch_count), 32'd1);
    cycle(1'b0, 8'h3C, 1'b0);
    hold(8'h3D, 1'b0, 4);
    chk("glitch2_count", 32'(glitch_count), 32'd2);
    chk("glitch2_valid", 32'(out_valid),    32'd1);
    chk("glitch2_data",  32'(out_data),     32'h3D);

    // overrun: latest wins, sticky flag
    cycle(1'b1, 8'h00, 1'b0);
    hold(8'h11, 1'b0, 3);
    chk("ovr_first", 32'(out_data), 32'h11);
    hold(8'h22, 1'b0, 3);
    chk("ovr_data",  32'(out_data),  32'h22);
    chk("ovr_valid", 32'(out_valid), 32'd1);
    chk("ovr_flag",  32'(overrun),   32'd1);
    cycle(1'b0, 8'h22, 1'b1);
    chk("ovr_accept", 32'(out_valid), 32'd0);
    chk("ovr_sticky", 32'(overrun),   32'd1);

    // commit coinciding with transfer
    cycle(1'b1, 8'h00, 1'b0);
    hold(8'h11, 1'b0, 3);
    hold(8'h22, 1'b0, 2);
    cycle(1'b0, 8'h22, 1'b1);
    chk("xfer_valid",   32'(out_valid), 32'd1);
    chk("xfer_data",    32'(out_data),  32'h22);
    chk("xfer_overrun", 32'(overrun),   32'd0);
    cycle(1'b0, 8'h22, 1'b0);

    // reset mid-stabilisation
    cycle(1'b1, 8'h00, 1'b0);
    hold(8'h77, 1'b0, 2);
    cycle(1'b1, 8'h77, 1'b0);
    hold(8'h77, 1'b0, S);
    chk("rst_mid_early", 32'(out_valid), 32'd0);
    cycle(1'b0, 8'h77, 1'b0);
    chk("rst_mid_valid", 32'(out_valid), 32'd1);
    chk("rst_mid_data",  32'(out_data),  32'h77);

    // randomized runs of values with random handshake and rare resets
    for (int n = 0; n < 800; n++) begin
      logic [7:0] v;
      int len;
      v = vals[$urandom_range(0, 4)];
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++)
        cycle(1'($urandom_range(0, 199) == 0), v, 1'($urandom_range(0, 2) == 0));
    end

    @(negedge clk);
    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_stable_capture.md
SYNC_STABLE_CAPTURE -- requirements
Module: sync_stable_capture

Interface
REQ-001 Parameter WIDTH, default 8, width of synchronized bus.
REQ-002 Parameter STABLE_CYCLES, default 2, consecutive repeat samples required to commit; legal range 1..15.
REQ-003 clk  input  1  single clock, the destination (slow) domain clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sync_in  input  WIDTH  bus output of the upstream two-stage synchronizer, may be transiently incoherent.
REQ-006 out_data  output  WIDTH  last committed stable value.
REQ-007 out_valid  output  1  committed value pending for consumer.
REQ-008 out_ready  input  1  consumer accepts out_data when high with out_valid.
REQ-009 glitch_count  output  16  number of abandoned (never-stable) candidates, saturating.
REQ-010 overrun  output  1  sticky flag: pending value overwritten before acceptance.

Function
REQ-011 Block SHALL hold internal registers cand (WIDTH), stab_cnt (4 bits), committed (WIDTH).
REQ-012 Each edge with sync_in != cand: cand <= sync_in, stab_cnt <= 0.
REQ-013 Each edge with sync_in == cand and stab_cnt < STABLE_CYCLES: stab_cnt <= stab_cnt + 1.
REQ-014 Each edge with sync_in == cand and stab_cnt == STABLE_CYCLES: stab_cnt holds (saturates).
REQ-015 Commit event SHALL occur on the edge where stab_cnt transitions STABLE_CYCLES-1 -> STABLE_CYCLES and cand != committed; on it committed <= cand.
REQ-016 Candidate reaching stability equal to committed SHALL produce no commit and no output.
REQ-017 Latency: value V first present on sync_in before edge k, held thereafter, SHALL give out_valid high after edge k+STABLE_CYCLES (default: 3 edges incl. capture).
REQ-018 Edge with sync_in != cand while stab_cnt < STABLE_CYCLES SHALL increment glitch_count, saturating at 16'hFFFF.
REQ-019 Change while stab_cnt == STABLE_CYCLES SHALL NOT count as glitch.
REQ-020 Handshake: transfer occurs on an edge with out_valid && out_ready; out_valid SHALL stay high and out_data constant until transfer, except per REQ-023.
REQ-021 Transfer without commit on same edge: out_valid <= 0, out_data holds.
REQ-022 Commit with out_valid low, or on a transfer edge: out_data <= cand, out_valid <= 1, overrun unchanged.
REQ-023 Commit with out_valid high and out_ready low: out_data <= cand (latest wins), out_valid stays 1, overrun <= 1.
REQ-024 overrun SHALL clear only on reset.
REQ-025 out_ready while out_valid low SHALL have no effect.
REQ-026 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-027 While rst high at an edge: cand <= 0, stab_cnt <= STABLE_CYCLES, committed <= 0, out_data <= 0, out_valid <= 0, glitch_count <= 0, overrun <= 0.
REQ-028 Reset SHALL override any commit, transfer or glitch on the same edge; pending value discarded.
REQ-029 After reset sync_in == 0 held SHALL produce no output and no glitch count.
REQ-030 Reset mid-stabilisation SHALL discard the candidate; counting restarts from sync_in after release.

Verification
REQ-031 Reset, sync_in 8'h00 held 20 cycles -> out_valid 0, glitch_count 0, overrun 0 throughout.
REQ-032 Default params, out_ready=1, sync_in 8'h00->8'hA5 held -> out_valid high exactly one cycle after third edge, out_data 8'hA5.
REQ-033 sync_in 8'h00->8'h3C one cycle->8'h00 -> no out_valid, glitch_count 1; then 8'h3C->8'h3D one cycle each ->8'h3D held -> glitch_count 2, commit 8'h3D.
REQ-034 out_ready=0, commit 8'h11 then sync_in->8'h22 held -> out_data 8'h22, out_valid 1, overrun 1; raise out_ready -> out_valid 0 next edge.
REQ-035 out_valid high with 8'h11, out_ready=1 on same edge as 8'h22 commit -> out_valid stays 1, out_data 8'h22, overrun 0.
REQ-036 rst asserted one cycle while stab_cnt==1 for 8'h77, sync_in held 8'h77 -> out_valid rises only STABLE_CYCLES+1 edges after rst release, out_data 8'h77.
